// File: rtl/wb_warmboot_ctl.sv
// Warm-boot control slave: key-protected arm/abort, prescaled countdown,
// and a two-cycle select-to-boot setup window before boot_now asserts.
module wb_warmboot_ctl #(
    parameter int          DELAY_W    = 16,
    parameter int          PRESCALE_W = 10,
    parameter logic [15:0] KEY        = 16'hB007
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  wb_addr,
    input  logic [31:0] wb_wdata,
    output logic [31:0] wb_rdata,
    input  logic        wb_we,
    input  logic        wb_cyc,
    output logic        wb_ack,
    output logic        boot_now,
    output logic [1:0]  boot_sel
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ARMED = 2'd1;
    localparam logic [1:0] S_SETUP = 2'd2;
    localparam logic [1:0] S_FIRE  = 2'd3;

    logic [1:0]            state;
    logic [DELAY_W-1:0]    delay;
    logic [DELAY_W-1:0]    count;
    logic [PRESCALE_W-1:0] presc;
    logic                  setup_cnt;
    logic                  key_err;

    logic        wr;
    logic        wr_ctrl;
    logic        key_ok;
    logic        arm_cmd;
    logic        abort_cmd;
    logic        arm_ok;
    logic        tick;
    logic [31:0] rd_mux;

    assign wr        = wb_cyc & wb_we & wb_ack;
    assign wr_ctrl   = wr & (wb_addr == 2'd0);
    assign key_ok    = (wb_wdata[31:16] == KEY);
    assign arm_cmd   = wr_ctrl & key_ok & wb_wdata[2] & ~wb_wdata[3];
    assign abort_cmd = wr_ctrl & key_ok & wb_wdata[3];
    assign arm_ok    = arm_cmd & ((state == S_IDLE) | (state == S_ARMED));
    assign tick      = &presc;
    assign boot_now  = (state == S_FIRE);

    always_comb begin
        rd_mux = '0;
        case (wb_addr)
            2'd0: begin
                rd_mux[31:30]        = state;
                rd_mux[29]           = key_err;
                rd_mux[17:16]        = boot_sel;
                rd_mux[DELAY_W-1:0]  = count;
            end
            2'd1:    rd_mux[DELAY_W-1:0] = delay;
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_ack   <= 1'b0;
            wb_rdata <= '0;
        end else begin
            wb_ack   <= wb_cyc & ~wb_ack;
            wb_rdata <= (wb_cyc & ~wb_ack) ? rd_mux : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            delay   <= '0;
            key_err <= 1'b0;
        end else begin
            if (wr && wb_addr == 2'd1)
                delay <= wb_wdata[DELAY_W-1:0];
            if (wr_ctrl)
                key_err <= ~key_ok;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            presc <= '0;
        else if (arm_ok)
            presc <= '0;
        else
            presc <= presc + 1'b1;
    end

    // Keyed commands take priority over the countdown in ARMED
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            count     <= '0;
            boot_sel  <= 2'd0;
            setup_cnt <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (arm_cmd) begin
                        state    <= S_ARMED;
                        count    <= delay;
                        boot_sel <= wb_wdata[1:0];
                    end
                end
                S_ARMED: begin
                    if (abort_cmd) begin
                        state    <= S_IDLE;
                        boot_sel <= 2'd0;
                    end else if (arm_cmd) begin
                        count    <= delay;
                        boot_sel <= wb_wdata[1:0];
                    end else if (count == '0) begin
                        state     <= S_SETUP;
                        setup_cnt <= 1'b0;
                    end else if (tick) begin
                        count <= count - 1'b1;
                    end
                end
                S_SETUP: begin
                    if (setup_cnt)
                        state <= S_FIRE;
                    else
                        setup_cnt <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_warmboot_ctl.sv
// Scoreboard bench for wb_warmboot_ctl: directed bus transactions push
// expected responses; a negedge monitor pops and compares on each ack.
module tb_wb_warmboot_ctl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  wb_addr;
    logic [31:0] wb_wdata;
    logic [31:0] wb_rdata;
    logic        wb_we;
    logic        wb_cyc;
    logic        wb_ack;
    logic        boot_now;
    logic [1:0]  boot_sel;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic        rd;
        logic [31:0] data;
        logic [31:0] mask;
    } exp_t;

    exp_t q[$];

    wb_warmboot_ctl #(
        .DELAY_W(16),
        .PRESCALE_W(2),
        .KEY(16'hB007)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .wb_addr(wb_addr),
        .wb_wdata(wb_wdata),
        .wb_rdata(wb_rdata),
        .wb_we(wb_we),
        .wb_cyc(wb_cyc),
        .wb_ack(wb_ack),
        .boot_now(boot_now),
        .boot_sel(boot_sel)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: compare read data on ack, require zero rdata otherwise
    always @(negedge clk) begin
        if (rst_n) begin
            if (wb_ack) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL ack_unexpected: got ack want none");
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    if (e.rd) begin
                        n_cmp++;
                        if ((wb_rdata & e.mask) !== (e.data & e.mask)) begin
                            n_bad++;
                            $display("FAIL rdata: got 0x%08h want 0x%08h mask 0x%08h",
                                     wb_rdata, e.data, e.mask);
                        end
                    end
                end
            end else begin
                n_cmp++;
                if (wb_rdata !== 32'h0) begin
                    n_bad++;
                    $display("FAIL rdata_idle: got 0x%08h want 0x00000000", wb_rdata);
                end
            end
        end
    end

    task automatic xfer(input logic we, input logic [1:0] addr,
                        input logic [31:0] wdata);
        int n;
        @(negedge clk);
        wb_cyc   = 1'b1;
        wb_we    = we;
        wb_addr  = addr;
        wb_wdata = wdata;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!wb_ack && n < 8);
        if (!wb_ack) begin
            chk("ack_timeout", 32'(wb_ack), 32'd1);
            wb_cyc = 1'b0;
            void'(q.pop_back());
        end else begin
            @(posedge clk);
            #1;
            wb_cyc = 1'b0;
            wb_we  = 1'b0;
        end
    endtask

    task automatic wr(input logic [1:0] addr, input logic [31:0] d);
        q.push_back('{rd: 1'b0, data: 32'h0, mask: 32'h0});
        xfer(1'b1, addr, d);
    endtask

    task automatic rd(input logic [1:0] addr, input logic [31:0] exp,
                      input logic [31:0] mask);
        q.push_back('{rd: 1'b1, data: exp, mask: mask});
        xfer(1'b0, addr, 32'h0);
    endtask

    task automatic wait_fire(input string name, input int exp_cyc);
        int k;
        k = 0;
        while (!boot_now && k < 60) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk(name, 32'(k), 32'(exp_cyc));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n  = 1'b0;
        wb_cyc = 1'b0;
        #1;
        chk("rst_boot_now", 32'(boot_now), 32'd0);
        chk("rst_boot_sel", 32'(boot_sel), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n    = 1'b0;
        wb_cyc   = 1'b1;
        wb_we    = 1'b0;
        wb_addr  = 2'd0;
        wb_wdata = 32'h0;
        repeat (3) @(negedge clk);
        chk("rst_ack", 32'(wb_ack), 32'd0);
        chk("rst_boot_now0", 32'(boot_now), 32'd0);
        chk("rst_boot_sel0", 32'(boot_sel), 32'd0);
        wb_cyc = 1'b0;
        rst_n  = 1'b1;
        rd(2'd0, 32'h0000_0000, 32'hFFFF_FFFF);

        // Countdown fire: DELAY=3, 4-clock prescale -> 15 clocks
        wr(2'd1, 32'd3);
        rd(2'd1, 32'd3, 32'hFFFF_FFFF);
        wr(2'd0, 32'hB007_0006);
        chk("arm_sel", 32'(boot_sel), 32'd2);
        wait_fire("fire_d3_cycles", 15);
        repeat (3) @(posedge clk);
        #1;
        chk("fire_sticky", 32'(boot_now), 32'd1);
        chk("fire_sel_hold", 32'(boot_sel), 32'd2);
        rd(2'd0, 32'hC002_0000, 32'hFFFF_FFFF);

        // Bad key then good key clears key_err
        do_reset();
        wr(2'd0, 32'h1234_0005);
        chk("badkey_sel", 32'(boot_sel), 32'd0);
        rd(2'd0, 32'h2000_0000, 32'hFFFF_FFFF);
        wr(2'd0, 32'hB007_0000);
        rd(2'd0, 32'h0000_0000, 32'hFFFF_FFFF);

        // Abort mid-count
        wr(2'd1, 32'd100);
        wr(2'd0, 32'hB007_0005);
        chk("abort_armsel", 32'(boot_sel), 32'd1);
        repeat (20) @(posedge clk);
        rd(2'd0, 32'h4001_0000, 32'hE003_0000);
        wr(2'd0, 32'hB007_0008);
        chk("abort_sel", 32'(boot_sel), 32'd0);
        rd(2'd0, 32'h0000_0000, 32'hE003_0000);
        repeat (450) @(posedge clk);
        #1;
        chk("abort_no_fire", 32'(boot_now), 32'd0);

        // Arm+abort together from IDLE stays IDLE
        wr(2'd0, 32'hB007_000D);
        chk("armabort_sel", 32'(boot_sel), 32'd0);
        rd(2'd0, 32'h0000_0000, 32'hE003_0000);

        // DELAY=0 fires 3 clocks after arm; later abort ignored
        wr(2'd1, 32'd0);
        wr(2'd0, 32'hB007_0005);
        chk("d0_sel", 32'(boot_sel), 32'd1);
        wait_fire("fire_d0_cycles", 3);
        wr(2'd0, 32'hB007_0008);
        chk("fire_abort_ign", 32'(boot_now), 32'd1);
        rd(2'd0, 32'hC001_0000, 32'hFFFF_FFFF);

        // Sustained cyc: alternating ack, reserved reads return 0
        do_reset();
        q.push_back('{rd: 1'b1, data: 32'h0, mask: 32'hFFFF_FFFF});
        q.push_back('{rd: 1'b1, data: 32'h0, mask: 32'hFFFF_FFFF});
        q.push_back('{rd: 1'b1, data: 32'h0, mask: 32'hFFFF_FFFF});
        @(negedge clk);
        wb_cyc  = 1'b1;
        wb_we   = 1'b0;
        wb_addr = 2'd2;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk($sformatf("ack_pat%0d", i), 32'(wb_ack), 32'(i % 2));
            @(negedge clk);
        end
        wb_cyc = 1'b0;
        wr(2'd3, 32'hFFFF_FFFF);
        rd(2'd3, 32'h0, 32'hFFFF_FFFF);
        rd(2'd2, 32'h0, 32'hFFFF_FFFF);
        rd(2'd1, 32'h0, 32'hFFFF_FFFF);

        repeat (4) @(posedge clk);
        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
